instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//   Fetch stage feeding the byte-addressed instruction memory and the decoder.
//   - Owns the PC and drives imem_addr.
//   - Captures the combinational imem_instr word into an IF/ID register with a valid/ready handshake.
//   - Resolves J-type jumps locally by predecode; accepts redirects from execute (beq, etc.).
// PARAMETERS
//   ADDR_W    8     PC / imem address width (byte address, 4-byte words)
//   RESET_PC  8'h00 PC value loaded on reset
//   CNT_W     16    width of the saturating retired-fetch counter
// PORTS
//   clk            in   1       rising-edge clock
//   rst_n          in   1       synchronous reset, active low
//   imem_addr      out  ADDR_W  byte address to instruction memory (= pc)
//   imem_instr     in   32      instruction word returned combinationally for imem_addr
//   redirect_valid in   1       execute-stage redirect request (taken branch)
//   redirect_pc    in   ADDR_W  redirect target byte address
//   halt_req       in   1       stop fetching after the current cycle
//   out_valid      out  1       IF/ID register holds a valid instruction
//   out_ready      in   1       decoder accepts IF/ID this cycle
//   out_instr      out  32      registered instruction
//   out_pc         out  ADDR_W  address of out_instr
//   out_pc_plus4   out  ADDR_W  out_pc + 4, modulo 2^ADDR_W
//   halted         out  1       FSM in HALTED
//   misalign_err   out  1       sticky: a redirect_pc with nonzero [1:0] was seen
//   fetch_count    out  CNT_W   instructions handed to decoder (valid & ready), saturating
// BEHAVIOUR
//   Clocking and reset:
//   - One clock; reset is synchronous and active low (rst_n sampled on posedge clk).
//   - Reset values: pc=RESET_PC; FSM=IDLE; out_valid=0; out_instr=0; out_pc=0; out_pc_plus4=0;
//     halted=0; misalign_err=0; fetch_count=0.
//   - Reset asserted mid-operation discards the IF/ID contents and any pending redirect.
//   FSM:
//   - IDLE    -> FETCH unconditionally after one cycle. No capture in IDLE.
//   - FETCH   -> HALTED when halt_req=1 and redirect_valid=0.
//   - HALTED  -> FETCH only on redirect_valid (pc <= redirect_pc). halt_req is ignored while HALTED.
//   IF/ID register:
//   - load = (FSM==FETCH) & (!out_valid | out_ready).
//   - On load: out_instr<=imem_instr; out_pc<=pc; out_pc_plus4<=pc+4; out_valid<=1.
//   - Entry accepted without load (consumed, not refilled): out_valid<=0.
//   - In HALTED the last entry is held until accepted, then out_valid<=0.
//   - Latency: imem_addr -> out_instr is exactly 1 cycle when not backpressured.
//   Next-PC priority, highest first:
//     1. redirect_valid: pc <= {redirect_pc[ADDR_W-1:2],2'b00}; out_valid<=0 (kills IF/ID even if
//        out_ready); sets misalign_err if redirect_pc[1:0]!=0. Wins over halt_req, backpressure, jump.
//     2. halt_req in FETCH: no load this cycle; pc unchanged.
//     3. !load (backpressure or IDLE/HALTED): pc unchanged; imem_addr stable.
//     4. load and imem_instr[31:26]==6'b000010 (j): pc <= {imem_instr[ADDR_W-3:0],2'b00}.
//        The jump itself is still loaded into IF/ID.
//     5. load otherwise: pc <= pc+4.
//   Arithmetic and counter:
//   - All PC arithmetic is modulo 2^ADDR_W; 8'hFC + 4 wraps to 8'h00 silently.
//   - fetch_count increments on out_valid & out_ready and saturates at all-ones.
// TESTING
//   1. Reset, then out_ready=1, no redirects:
//      -> out_valid first rises after 2 cycles; out_pc = 0, 4, 8, ... with out_instr matching memory.
//   2. out_ready=0 for 3 cycles while out_pc=8:
//      -> out_pc, out_instr and imem_addr(=12) held; after release, continues with out_pc = 12.
//   3. Jump word 32'h08000100 fetched at 40:
//      -> the jump appears at out_pc=40; next fetched out_pc=0 (0x100<<2 mod 256); no pc+4 fetch at 44.
//   4. redirect_valid with redirect_pc=8'h0E while out_ready=0:
//      -> out_valid=0 next cycle; imem_addr=8'h0C; misalign_err=1 and stays 1.
//   5. halt_req pulse at pc=16, then redirect_valid with redirect_pc=4 after 5 cycles:
//      -> halted=1; pending entry drains; imem_addr holds 16; then FETCH resumes at 4.
//   6. rst_n low for 1 cycle mid-stream with out_valid=1:
//      -> next cycle out_valid=0, pc=0, fetch_count=0. Also preload fetch_count near all-ones and
//      check it saturates.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bus: instruction memory request/response plus the IF/ID
// valid/ready handshake toward the decoder.
interface instruction_fetch_unit_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_instr;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic [ADDR_W-1:0] out_pc_plus4;

  modport master (
    output imem_addr,
    input  imem_instr,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output out_pc_plus4
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  out_pc_plus4
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, captures imem words into the IF/ID register,
// predecodes J-type jumps and honours execute-stage redirects and halts.
module instruction_fetch_unit #(
  parameter int             ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
  parameter int             CNT_W    = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  instruction_fetch_unit_if.master      bus,
  input  logic                          redirect_valid,
  input  logic [ADDR_W-1:0]             redirect_pc,
  input  logic                          halt_req,
  output logic                          halted,
  output logic                          misalign_err,
  output logic [CNT_W-1:0]              fetch_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] pc_r;
  logic              out_valid_r;
  logic [31:0]       out_instr_r;
  logic [ADDR_W-1:0] out_pc_r;
  logic [ADDR_W-1:0] out_pc_plus4_r;
  logic              halted_r;
  logic              misalign_err_r;
  logic [CNT_W-1:0]  fetch_count_r;

  logic              accept_s;
  logic              load_s;
  logic              is_jump_s;
  logic              cnt_full_s;
  logic [ADDR_W-1:0] pc_plus4_s;
  logic [ADDR_W-1:0] jump_target_s;

  assign accept_s      = out_valid_r & bus.out_ready;
  assign load_s        = (state_r == ST_FETCH) & (~out_valid_r | bus.out_ready);
  assign is_jump_s     = (bus.imem_instr[31:26] == 6'b000010);
  assign cnt_full_s    = (fetch_count_r == {CNT_W{1'b1}});
  assign pc_plus4_s    = pc_r + ADDR_W'(4);
  assign jump_target_s = {bus.imem_instr[ADDR_W-3:0], 2'b00};

  // FSM, PC, IF/ID register and status flags; redirect outranks every other update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      pc_r           <= RESET_PC;
      out_valid_r    <= 1'b0;
      out_instr_r    <= 32'h0000_0000;
      out_pc_r       <= {ADDR_W{1'b0}};
      out_pc_plus4_r <= {ADDR_W{1'b0}};
      halted_r       <= 1'b0;
      misalign_err_r <= 1'b0;
      fetch_count_r  <= {CNT_W{1'b0}};
    end else begin
      if (accept_s && !cnt_full_s) begin
        fetch_count_r <= fetch_count_r + CNT_W'(1);
      end
      if (redirect_valid) begin
        // Killing IF/ID even when accepted keeps wrong-path words out of decode
        pc_r        <= {redirect_pc[ADDR_W-1:2], 2'b00};
        out_valid_r <= 1'b0;
        state_r     <= ST_FETCH;
        halted_r    <= 1'b0;
        if (redirect_pc[1:0] != 2'b00) begin
          misalign_err_r <= 1'b1;
        end
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r  <= ST_FETCH;
            halted_r <= 1'b0;
          end
          ST_FETCH: begin
            if (halt_req) begin
              state_r  <= ST_HALTED;
              halted_r <= 1'b1;
              if (accept_s) begin
                out_valid_r <= 1'b0;
              end
            end else if (load_s) begin
              out_instr_r    <= bus.imem_instr;
              out_pc_r       <= pc_r;
              out_pc_plus4_r <= pc_plus4_s;
              out_valid_r    <= 1'b1;
              pc_r           <= is_jump_s ? jump_target_s : pc_plus4_s;
            end
          end
          ST_HALTED: begin
            if (accept_s) begin
              out_valid_r <= 1'b0;
            end
          end
          default: begin
            state_r     <= ST_IDLE;
            halted_r    <= 1'b0;
            out_valid_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.imem_addr    = pc_r;
  assign bus.out_valid    = out_valid_r;
  assign bus.out_instr    = out_instr_r;
  assign bus.out_pc       = out_pc_r;
  assign bus.out_pc_plus4 = out_pc_plus4_r;
  assign halted           = halted_r;
  assign misalign_err     = misalign_err_r;
  assign fetch_count      = fetch_count_r;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus randomized traffic
// checked against a transaction-level reference model of the fetch stage.
module tb_instruction_fetch_unit;
  localparam int ADDR_W = 8;
  localparam int CNT_W  = 8;
  localparam int CMAX   = 255;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = 8'h00;
  logic              halt_req = 1'b0;
  logic              halted;
  logic              misalign_err;
  logic [CNT_W-1:0]  fetch_count;

  logic [31:0] mem [0:63];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (plain integers)
  int          m_pc, m_mode, m_cnt;   // mode: 0 idle, 1 fetching, 2 halted
  bit          m_v, m_mis;
  logic [31:0] m_instr;
  int          m_opc;

  instruction_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

  assign bus.imem_instr = mem[bus.imem_addr[7:2]];

  instruction_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(8'h00), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .halted         (halted),
    .misalign_err   (misalign_err),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  // Advance one clock; the model consumes the same inputs the DUT sees at the edge
  task automatic tick();
    int pc = m_pc, mode = m_mode, cnt = m_cnt, opc = m_opc;
    bit v = m_v, mis = m_mis;
    logic [31:0] ins = m_instr;
    bit accept = m_v && bus.out_ready;
    logic [31:0] w;
    if (accept && cnt < CMAX) cnt = cnt + 1;
    if (!rst_n) begin
      pc = 0; mode = 0; cnt = 0; v = 0; mis = 0; ins = 0; opc = 0;
    end else if (redirect_valid) begin
      pc = (int'(redirect_pc) / 4) * 4;
      v = 0; mode = 1;
      if (int'(redirect_pc) % 4 != 0) mis = 1;
    end else if (mode == 0) begin
      mode = 1;
    end else if (mode == 2) begin
      if (accept) v = 0;
    end else if (halt_req) begin
      mode = 2;
      if (accept) v = 0;
    end else if (!m_v || bus.out_ready) begin
      w = mem[pc / 4];
      ins = w; opc = pc; v = 1;
      if (w[31:26] == 6'b000010) pc = (int'(w) % 64) * 4;
      else pc = (pc + 4) % 256;
    end
    @(posedge clk);
    #1;
    m_pc = pc; m_mode = mode; m_cnt = cnt; m_v = v; m_mis = mis; m_instr = ins; m_opc = opc;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | i;
    mem[10] = 32'h0800_0100;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.imem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_pc: got %h want 00", bus.imem_addr); end
    n_checks++; if (bus.out_instr !== 32'h0 || bus.out_pc !== 8'h00 || bus.out_pc_plus4 !== 8'h00) begin n_fail++; $display("FAIL reset_ifid: got %h %h %h want zeros", bus.out_instr, bus.out_pc, bus.out_pc_plus4); end
    n_checks++; if (halted !== 1'b0 || misalign_err !== 1'b0 || fetch_count !== 8'h00) begin n_fail++; $display("FAIL reset_status: got %b %b %h want 0 0 00", halted, misalign_err, fetch_count); end
  endtask

  task automatic test_stream();
    bus.out_ready = 1'b1;
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_idle: got valid %b want 0", bus.out_valid); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'(4 * k) || bus.out_instr !== (32'hA000_0000 | k) || bus.out_pc_plus4 !== 8'(4 * k + 4)) begin
        n_fail++; $display("FAIL stream_%0d: got v=%b pc=%h ins=%h p4=%h want pc=%h", k, bus.out_valid, bus.out_pc, bus.out_instr, bus.out_pc_plus4, 4 * k);
      end
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (bus.out_pc !== 8'h08 || bus.out_instr !== 32'hA000_0002 || bus.imem_addr !== 8'h0C || bus.out_valid !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold_%0d: got pc=%h ins=%h addr=%h want 08 a0000002 0c", k, bus.out_pc, bus.out_instr, bus.imem_addr);
      end
    end
    bus.out_ready = 1'b1;
    tick();
    n_checks++; if (bus.out_pc !== 8'h0C) begin n_fail++; $display("FAIL bp_release: got pc=%h want 0c", bus.out_pc); end
  endtask

  task automatic test_jump();
    for (int i = 0; i < 20 && bus.out_pc !== 8'd40; i++) tick();
    n_checks++; if (bus.out_pc !== 8'd40 || bus.out_instr !== 32'h0800_0100) begin n_fail++; $display("FAIL jump_entry: got pc=%h ins=%h want 28 08000100", bus.out_pc, bus.out_instr); end
    n_checks++; if (bus.imem_addr !== 8'h00) begin n_fail++; $display("FAIL jump_target: got addr=%h want 00", bus.imem_addr); end
    tick();
    n_checks++; if (bus.out_pc !== 8'h00 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL jump_next: got pc=%h v=%b want 00 1", bus.out_pc, bus.out_valid); end
  endtask

  task automatic test_misalign_redirect();
    bus.out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 8'h0E;
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.imem_addr !== 8'h0C || misalign_err !== 1'b1) begin n_fail++; $display("FAIL redirect_mis: got v=%b addr=%h mis=%b want 0 0c 1", bus.out_valid, bus.imem_addr, misalign_err); end
    bus.out_ready = 1'b1;
    tick();
    n_checks++; if (bus.out_pc !== 8'h0C || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL redirect_fetch: got pc=%h v=%b want 0c 1", bus.out_pc, bus.out_valid); end
    tick();
    n_checks++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL misalign_sticky: got %b want 1", misalign_err); end
  endtask

  task automatic test_halt();
    redirect_valid = 1'b1; redirect_pc = 8'h0C;
    tick();
    redirect_valid = 1'b0;
    tick();
    bus.out_ready = 1'b0; halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    n_checks++; if (halted !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_pc !== 8'h0C || bus.imem_addr !== 8'h10) begin n_fail++; $display("FAIL halt_enter: got h=%b v=%b pc=%h addr=%h want 1 1 0c 10", halted, bus.out_valid, bus.out_pc, bus.imem_addr); end
    bus.out_ready = 1'b1;
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL halt_drain: got v=%b want 0", bus.out_valid); end
    halt_req = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    halt_req = 1'b0;
    n_checks++; if (halted !== 1'b1 || bus.imem_addr !== 8'h10 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL halt_hold: got h=%b addr=%h v=%b want 1 10 0", halted, bus.imem_addr, bus.out_valid); end
    redirect_valid = 1'b1; redirect_pc = 8'h04;
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (halted !== 1'b0 || bus.imem_addr !== 8'h04) begin n_fail++; $display("FAIL halt_resume: got h=%b addr=%h want 0 04", halted, bus.imem_addr); end
    tick();
    n_checks++; if (bus.out_pc !== 8'h04 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL halt_refetch: got pc=%h v=%b want 04 1", bus.out_pc, bus.out_valid); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    for (int c = 0; c < 600; c++) begin
      bus.out_ready  = ($urandom_range(3) != 0);
      redirect_valid = ($urandom_range(19) == 0);
      redirect_pc    = 8'($urandom);
      halt_req       = ($urandom_range(19) == 0);
      tick();
      n_checks++;
      if (bus.out_valid !== m_v || bus.imem_addr !== 8'(m_pc) || halted !== (m_mode == 2) || misalign_err !== m_mis || fetch_count !== 8'(m_cnt)) begin
        n_fail++; $display("FAIL rand_ctl cyc %0d: got v=%b a=%h h=%b m=%b c=%0d want %b %h %b %b %0d", c, bus.out_valid, bus.imem_addr, halted, misalign_err, fetch_count, m_v, 8'(m_pc), m_mode == 2, m_mis, m_cnt);
      end
      if (m_v) begin
        n_checks++;
        if (bus.out_instr !== m_instr || bus.out_pc !== 8'(m_opc) || bus.out_pc_plus4 !== 8'((m_opc + 4) % 256)) begin
          n_fail++; $display("FAIL rand_data cyc %0d: got %h %h %h want %h %h", c, bus.out_instr, bus.out_pc, bus.out_pc_plus4, m_instr, 8'(m_opc));
        end
      end
    end
    redirect_valid = 1'b0; halt_req = 1'b0;
  endtask

  task automatic test_saturation();
    bus.out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 8'h00;
    tick();
    redirect_valid = 1'b0;
    for (int c = 0; c < 300; c++) tick();
    n_checks++; if (fetch_count !== 8'hFF || m_cnt != CMAX) begin n_fail++; $display("FAIL count_sat: got %h want ff", fetch_count); end
    for (int c = 0; c < 5; c++) tick();
    n_checks++; if (fetch_count !== 8'hFF) begin n_fail++; $display("FAIL count_hold: got %h want ff", fetch_count); end
  endtask

  task automatic test_reset_midstream();
    bus.out_ready = 1'b1;
    tick();
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid: got %b want 1", bus.out_valid); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.imem_addr !== 8'h00 || fetch_count !== 8'h00 || halted !== 1'b0 || misalign_err !== 1'b0) begin n_fail++; $display("FAIL midreset: got v=%b a=%h c=%h h=%b m=%b want 0 00 00 0 0", bus.out_valid, bus.imem_addr, fetch_count, halted, misalign_err); end
    tick(); tick();
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'h00 || bus.out_instr !== mem[0]) begin n_fail++; $display("FAIL midreset_restart: got v=%b pc=%h ins=%h want 1 00 %h", bus.out_valid, bus.out_pc, bus.out_instr, mem[0]); end
  endtask

  initial begin
    m_pc = 0; m_mode = 0; m_cnt = 0; m_v = 0; m_mis = 0; m_instr = 32'h0; m_opc = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_jump();
    test_misalign_redirect();
    test_halt();
    test_random();
    test_saturation();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
